// File: rtl/ddr_wr_burst_packer.sv
// Host write beats grouped into sequential-address bursts and pushed
// into the command/data async FIFO as a header entry plus data entries.
module ddr_wr_burst_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 16,
    parameter int LEN_W      = $clog2(BURST_LEN) + 1
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush,
    input  logic                  full,
    output logic                  w_en,
    output logic [DATA_WIDTH:0]   wdata,
    output logic                  busy
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HDR,
        S_DRAIN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [BURST_LEN];
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_W-1:0]      count;
    logic [IDX_W-1:0]      idx;
    logic [TO_W-1:0]       idle;
    logic                  pend_v;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  rdy_en;

    logic                  accept;
    logic                  seq;
    logic                  to_hit;
    logic                  last;
    logic [DATA_WIDTH-1:0] hdr;

    // rdy_en keeps in_ready low while reset is asserted
    assign in_ready = rdy_en && !pend_v &&
                      (state == S_IDLE || state == S_COLLECT);
    assign accept   = in_valid && in_ready;
    assign seq      = (in_addr == next_addr) && (in_addr != '0);
    assign to_hit   = idle >= TO_W'(TIMEOUT - 1);
    assign last     = LEN_W'(idx) == count - LEN_W'(1);
    assign w_en     = (state == S_HDR || state == S_DRAIN) && !full;
    assign busy     = (state != S_IDLE) || pend_v;

    always_comb begin
        hdr = '0;
        hdr[ADDR_WIDTH-1:0] = start_addr;
        hdr[ADDR_WIDTH +: LEN_W] = count;
    end

    always_comb begin
        wdata = '0;
        unique case (state)
            S_HDR:   wdata = {1'b1, hdr};
            S_DRAIN: wdata = {1'b0, mem[idx]};
            default: wdata = '0;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= S_IDLE;
            for (int i = 0; i < BURST_LEN; i++) mem[i] <= '0;
            start_addr <= '0;
            next_addr  <= '0;
            count      <= '0;
            idx        <= '0;
            idle       <= '0;
            pend_v     <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            rdy_en     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (pend_v) begin
                        mem[0]     <= pend_data;
                        start_addr <= pend_addr;
                        next_addr  <= pend_addr + 1'b1;
                        count      <= LEN_W'(1);
                        idle       <= '0;
                        pend_v     <= 1'b0;
                        state      <= S_COLLECT;
                    end else if (accept) begin
                        mem[0]     <= in_data;
                        start_addr <= in_addr;
                        next_addr  <= in_addr + 1'b1;
                        count      <= LEN_W'(1);
                        idle       <= '0;
                        state      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        idle <= '0;
                        if (seq) begin
                            mem[count[IDX_W-1:0]] <= in_data;
                            count     <= count + 1'b1;
                            next_addr <= next_addr + 1'b1;
                            if (count == LEN_W'(BURST_LEN - 1) || flush)
                                state <= S_HDR;
                        end else begin
                            // address-space wrap also lands here
                            pend_v    <= 1'b1;
                            pend_addr <= in_addr;
                            pend_data <= in_data;
                            state     <= S_HDR;
                        end
                    end else begin
                        if (idle != TO_W'(TIMEOUT))
                            idle <= idle + 1'b1;
                        if (flush || to_hit)
                            state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (!full) begin
                        idx   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!full) begin
                        if (last) begin
                            count <= '0;
                            idx   <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
